obi_wb_bridge: RTL and testbench

//  Converts one core-side OBI port (req/gnt/rvalid, zeroriscy instr or data port) into a pipelined

---
 rtl/obi_wb_bridge.sv | 145 ++++++++++++++
 tb/tb_obi_wb_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_wb_bridge.sv
// OBI (req/gnt/rvalid) slave port to pipelined Wishbone B4 master bridge.
// Handles one transaction at a time, registers the response and turns a
// missing Wishbone response into an OBI error after a bounded number of cycles.
module obi_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          WRITE_RVALID   = 1'b1
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  // OBI side
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  // Wishbone side
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_stall_i
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic                  wb_cyc_q, wb_stb_q, wb_we_q;
  logic [BeW-1:0]        wb_sel_q;
  logic [ADDR_WIDTH-1:0] wb_adr_q;
  logic [DATA_WIDTH-1:0] wb_dat_q;
  logic                  rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CntW-1:0]       cnt_q;

  logic wb_done;
  logic timeout_hit;
  logic resp_vis;

  // Completion: any response in WAIT, or a response on the cycle the strobe is accepted.
  always_comb begin
    wb_done     = (wb_ack_i | wb_err_i) &
                  ((state_q == StWait) | ((state_q == StIssue) & ~wb_stall_i));
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);
    // Silent writes still walk through RESP but never pulse rvalid or touch the response.
    resp_vis    = ~wb_we_q | WRITE_RVALID;
    gnt_o       = (state_q == StIdle) & req_i;
  end

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q  <= StIdle;
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_sel_q <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_i) begin
            wb_we_q  <= we_i;
            wb_sel_q <= be_i;
            wb_adr_q <= addr_i;
            wb_dat_q <= wdata_i;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (wb_done) begin
            wb_cyc_q <= 1'b0;
            wb_stb_q <= 1'b0;
            rvalid_q <= resp_vis;
            if (resp_vis) begin
              // err_i beats ack_i when both arrive together.
              err_q   <= wb_err_i;
              rdata_q <= (wb_err_i || wb_we_q) ? '0 : wb_dat_i;
            end
            state_q  <= StResp;
          end else if (timeout_hit) begin
            wb_cyc_q <= 1'b0;
            wb_stb_q <= 1'b0;
            rvalid_q <= resp_vis;
            if (resp_vis) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
            state_q  <= StResp;
          end else begin
            if ((state_q == StIssue) && !wb_stall_i) begin
              wb_stb_q <= 1'b0;
              state_q  <= StWait;
            end
            if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StResp: begin
          rvalid_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wb_cyc_o = wb_cyc_q;
  assign wb_stb_o = wb_stb_q;
  assign wb_we_o  = wb_we_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Bench for obi_wb_bridge: a driver issues OBI requests and plays the Wishbone
// slave; expected responses go into a queue that a monitor drains on rvalid_o.
module tb_obi_wb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          req_i, gnt_o, we_i;
  logic [3:0]    be_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o, err_o;
  logic [DW-1:0] rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_stall_i;

  obi_wb_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T),
    .WRITE_RVALID  (1'b1)
  ) dut (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  always #5 clk_core = ~clk_core;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk_core) begin
    if (!rst_core && rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata", 64'(rdata_o), 64'(mon_e.rdata));
        check("err", 64'(err_o), 64'(mon_e.err));
      end
    end
  end

  // mode: 0 ack, 1 err, 2 ack+err, 3 no response. Called at a negedge with the DUT idle.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rdat,
                         input int mode, input int stall_n, input int lat);
    int    resp_c  = stall_n + 1 + lat;  // ISSUE+WAIT cycles until the slave answers
    bit    to      = (mode == 3) || (resp_c > T);
    int    exp_c   = to ? T : resp_c;
    int    exp_acc = (stall_n + 1 <= T) ? 1 : 0;
    int    c       = 0;
    int    acc     = 0;
    resp_t e;
    e.err   = to || (mode == 1) || (mode == 2);
    e.rdata = (e.err || we) ? '0 : rdat;

    req_i   = 1'b1;
    we_i    = we;
    be_i    = be;
    addr_i  = addr;
    wdata_i = wdata;
    #1;
    check("gnt_idle", 64'(gnt_o), 64'd1);
    exp_q.push_back(e);
    @(negedge clk_core);
    while (c < 64) begin
      c++;
      check("cyc", 64'(wb_cyc_o), 64'd1);
      check("stb", 64'(wb_stb_o), 64'(c <= stall_n + 1));
      check("we", 64'(wb_we_o), 64'(we));
      check("sel", 64'(wb_sel_o), 64'(be));
      check("adr", 64'(wb_adr_o), 64'(addr));
      check("dat_o", 64'(wb_dat_o), 64'(wdata));
      // Request lines wiggle while busy; none of it may be granted or latched.
      req_i   = 1'($urandom);
      we_i    = 1'($urandom);
      addr_i  = $urandom;
      wdata_i = $urandom;
      #1;
      check("gnt_busy", 64'(gnt_o), 64'd0);
      wb_stall_i = (c <= stall_n);
      if (mode != 3 && c == resp_c) begin
        wb_ack_i = (mode != 1);
        wb_err_i = (mode != 0);
        wb_dat_i = rdat;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
      end
      if (wb_stb_o && !wb_stall_i) acc++;
      @(negedge clk_core);
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_stall_i = 1'b0;
      req_i      = 1'b0;
      if (!wb_cyc_o) break;
    end
    check("busy_cycles", 64'(c), 64'(exp_c));
    check("stb_accepts", 64'(acc), 64'(exp_acc));
    // RESP cycle: a stray ack here must not produce anything.
    wb_ack_i = 1'($urandom);
    @(negedge clk_core);
    wb_ack_i = 1'b0;
  endtask

  initial begin
    rst_core   = 1'b1;
    req_i      = 1'b0;
    we_i       = 1'b0;
    be_i       = '0;
    addr_i     = '0;
    wdata_i    = '0;
    wb_dat_i   = '0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
    repeat (2) @(negedge clk_core);
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_we", 64'(wb_we_o), 64'd0);
    check("rst_sel", 64'(wb_sel_o), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    rst_core = 1'b0;
    @(negedge clk_core);

    // Directed cases.
    run_txn(1'b0, 4'hf, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 2);   // read
    run_txn(1'b1, 4'h3, 32'h204, 32'h1234, 32'h55AA55AA, 0, 0, 1); // write
    run_txn(1'b0, 4'hf, 32'h108, 32'h0, 32'hCAFEF00D, 0, 5, 1);   // stall 5
    run_txn(1'b0, 4'hf, 32'h10C, 32'h0, 32'h0BADF00D, 3, 0, 0);   // timeout
    wb_ack_i = 1'b1;                                               // late stray ack in IDLE
    @(negedge clk_core);
    wb_ack_i = 1'b0;
    run_txn(1'b0, 4'hf, 32'h110, 32'h0, 32'h12345678, 2, 0, 1);   // ack+err together
    run_txn(1'b0, 4'hf, 32'h114, 32'h0, 32'h87654321, 0, 0, 0);   // ack at accept
    run_txn(1'b0, 4'hf, 32'h118, 32'h0, 32'hA5A5A5A5, 0, 3, 12);  // ack exactly at limit
    run_txn(1'b1, 4'h1, 32'h11C, 32'h99, 32'h0, 1, 2, 3);         // write error

    // Reset while waiting for the slave.
    req_i  = 1'b1;
    we_i   = 1'b0;
    be_i   = 4'hf;
    addr_i = 32'h300;
    @(negedge clk_core);
    req_i = 1'b0;
    @(negedge clk_core);
    #2 rst_core = 1'b1;
    #1;
    check("rst_mid_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_mid_stb", 64'(wb_stb_o), 64'd0);
    @(negedge clk_core);
    rst_core = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF0000;
    @(negedge clk_core);
    wb_ack_i = 1'b0;
    run_txn(1'b0, 4'hf, 32'h304, 32'h0, 32'h0F0F0F0F, 0, 1, 2);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int r    = $urandom_range(0, 9);
      int mode = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
      run_txn(1'($urandom), 4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
              mode, $urandom_range(0, 6), $urandom_range(0, 12));
    end

    repeat (3) @(negedge clk_core);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
